cs_bist_driver: RTL and testbench
=================================

// Module: cs_bist_driver
// PURPOSE
//  Hardware stimulus/response harness for the CS sliding-window block (X in 8b, Y out 10b).
//  Drives CS: DUT reset sequence, pseudo-random X stream, one sample per cycle.
//  Captures every valid Y into a 32b MISR and compares the final signature against GOLDEN_SIG.
//  Result is a single pass/done flag. Sits beside CS as the silicon self-test wrapper.
// PARAMETERS
//  N_PAT        2000      samples driven per run (>= 9)
//  WIN          9         window depth; first valid Y follows sample WIN-1
//  LAT          1         cycles from sample k on X to Y(k) valid at a clk edge (1..8)
//  DUT_RST_CYC  2         cycles dut_reset is held high before streaming
//  LFSR_SEED    8'hA5     X generator seed; 8'h00 is replaced by 8'h01
//  SIG_INIT     32'hFFFFFFFF  MISR initial value
//  GOLDEN_SIG   32'h0     expected final MISR value
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  reset      in   1   synchronous, active-low
//  start      in   1   1-cycle pulse; starts a run from IDLE or DONE; ignored while busy
//  Y          in   10  CS output
//  X          out  8   CS input sample, registered
//  dut_reset  out  1   CS reset, active-high, registered
//  busy       out  1   high in DRST/STREAM/DRAIN
//  done       out  1   high in DONE
//  pass       out  1   valid when done: signature == GOLDEN_SIG and cap_cnt == N_PAT-WIN+1
//  signature  out  32  current MISR value
//  cap_cnt    out  16  number of Y values captured this run
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, X=seed, dut_reset=1, busy=0, done=0, pass=0,
//   signature=SIG_INIT, cap_cnt=0, capture pipeline cleared. Mid-run reset aborts; nothing is retained.
//  FSM: IDLE -start-> DRST -after DUT_RST_CYC cycles-> STREAM -after N_PAT samples-> DRAIN
//   -after LAT cycles-> DONE -start-> DRST. In IDLE and DONE, dut_reset=1 and X holds its value.
//  On start: X=seed, signature=SIG_INIT, cap_cnt=0, pass=0, and dut_reset=1 for exactly DUT_RST_CYC cycles.
//  STREAM: dut_reset=0. Sample index s (0..N_PAT-1) is on X for exactly one cycle.
//   X(s+1)={X(s)[6:0], X[7]^X[5]^X[4]^X[3]} (x^8+x^6+x^5+x^4+1).
//   Sample sequence from seed A5: A5, 4A, 95, ...
//  DRAIN: X holds its last value; dut_reset=0; remaining captures complete.
//  Capture: sample s with s>=WIN-1 marks a valid flag. A LAT-deep shift register delays the flag.
//   At the posedge where the delayed flag is 1:
//   signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ {22'b0, Y}; cap_cnt <= cap_cnt+1.
//  Total captures are N_PAT-WIN+1. cap_cnt saturates at 16'hFFFF.
//  pass is registered on DONE entry and holds until the next start or reset.
//  start while busy has no effect. start on the same edge as reset==0: reset wins.
// TESTING
//  1) Reset low 3 cycles, then high -> X=A5, dut_reset=1, busy=0, done=0, signature=FFFFFFFF.
//  2) start pulse -> dut_reset high 2 cycles, then X=A5,4A,95 on consecutive cycles with dut_reset=0.
//  3) N_PAT=16, LAT=1, Y tied to 10'h000 -> cap_cnt=8. done rises 2+16+1 cycles after DRST entry.
//     signature = SIG_INIT shifted 8 times with no Y injection.
//  4) Real CS attached, GOLDEN_SIG taken from the behavioural model -> done=1, pass=1.
//     Flipping Y[0] on any single capture -> pass=0.
//  5) Assert reset mid-STREAM, then start again -> the run restarts from X=A5.
//     Final signature matches test 4 (no state carried over).
//  6) start pulses during STREAM -> ignored. start in DONE -> new run; pass cleared on that cycle.

Source files
------------

// File: rtl/cs_bist_driver.sv
// -----------------------------------------------------------------------------
// cs_bist_driver
//   Self-test wrapper for the CS sliding-window block. After a start pulse it
//   holds CS in reset for DUT_RST_CYC cycles, streams N_PAT pseudo-random
//   samples (8-bit LFSR, x^8+x^6+x^5+x^4+1) one per cycle, then waits LAT
//   cycles for the last responses. Every valid Y is folded into a 32-bit
//   MISR. On entry to DONE the signature and capture count are compared
//   against GOLDEN_SIG and N_PAT-WIN+1 to form the pass flag.
//
// Ports
//   clk        in   single clock, posedge
//   reset      in   synchronous, active-low
//   start      in   1-cycle pulse, accepted in IDLE or DONE only
//   Y          in   10-bit CS output
//   X          out  8-bit CS input sample (registered)
//   dut_reset  out  CS reset, active-high (registered)
//   busy       out  high in DRST/STREAM/DRAIN
//   done       out  high in DONE
//   pass       out  result, registered on DONE entry
//   signature  out  current MISR value
//   cap_cnt    out  number of Y values captured this run (saturating)
// -----------------------------------------------------------------------------
module cs_bist_driver #(
    parameter int          N_PAT       = 2000,
    parameter int          WIN         = 9,
    parameter int          LAT         = 1,
    parameter int          DUT_RST_CYC = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter logic [31:0] SIG_INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  Y,
    output logic [7:0]  X,
    output logic        dut_reset,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [15:0] cap_cnt
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] CAP_GOAL = 16'(N_PAT - WIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       phase_cnt;
    logic [LAT-1:0]    vld_p;
    logic              start_acc;
    logic              cap_flag;
    logic              cap_fire;
    logic [31:0]       sig_nxt;
    logic [15:0]       cnt_nxt;

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [9:0] y);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {22'b0, y};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_DRST;
                    start_acc = 1'b1;
                end
            end
            S_DRST: begin
                busy = 1'b1;
                if (phase_cnt == 32'(DUT_RST_CYC - 1)) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                if (phase_cnt == 32'(N_PAT - 1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (phase_cnt == 32'(LAT - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = S_DRST;
                    start_acc = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: sample index >= WIN-1 is the first with a full window.
    assign cap_flag = (state == S_STREAM) && (phase_cnt >= 32'(WIN - 1));

    // Stage p(LAT-1): the flag has caught up with the matching Y.
    assign cap_fire = vld_p[LAT-1];
    assign sig_nxt  = cap_fire ? misr_step(signature, Y) : signature;
    assign cnt_nxt  = cap_fire ? sat_inc(cap_cnt) : cap_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            vld_p     <= '0;
            X         <= SEED;
            dut_reset <= 1'b1;
            pass      <= 1'b0;
            signature <= SIG_INIT;
            cap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            // Phase counter restarts on every state change and idles at zero.
            phase_cnt <= (state_nxt != state || !busy) ? 32'd0 : phase_cnt + 32'd1;
            dut_reset <= !(state_nxt == S_STREAM || state_nxt == S_DRAIN);
            if (start_acc) begin
                X         <= SEED;
                signature <= SIG_INIT;
                cap_cnt   <= '0;
                pass      <= 1'b0;
                vld_p     <= '0;
            end else begin
                vld_p[0] <= cap_flag;
                for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
                signature <= sig_nxt;
                cap_cnt   <= cnt_nxt;
                // Advance only while another sample follows, so the last one holds in DRAIN.
                if (state == S_STREAM && state_nxt == S_STREAM) X <= lfsr_step(X);
                // The final capture lands on the DONE-entry edge, so judge the next-state values.
                if (state == S_DRAIN && state_nxt == S_DONE)
                    pass <= (sig_nxt == GOLDEN_SIG) && (cnt_nxt == CAP_GOAL);
            end
        end
    end

endmodule

// File: tb/tb_cs_bist_driver.sv
module tb_cs_bist_driver;

    localparam int          N_PAT    = 16;
    localparam int          WIN      = 9;
    localparam int          LAT      = 1;
    localparam int          DRC      = 2;
    localparam logic [7:0]  SEED     = 8'hA5;
    localparam logic [31:0] SIG_INIT = 32'hFFFFFFFF;

    // Run timeline in cycles counted from the first DRST cycle.
    localparam int C_STR  = DRC;
    localparam int C_DRN  = DRC + N_PAT;
    localparam int C_DONE = DRC + N_PAT + LAT;
    localparam int CAP_LO = DRC + WIN - 1 + LAT;
    localparam int CAP_HI = DRC + N_PAT - 1 + LAT;
    localparam int N_CAP  = N_PAT - WIN + 1;

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [9:0] y);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {22'b0, y};
    endfunction

    function automatic logic [31:0] zero_sig();
        logic [31:0] s;
        s = SIG_INIT;
        for (int i = 0; i < N_CAP; i++) s = misr(s, 10'd0);
        return s;
    endfunction

    // Golden signature for a run with Y held at zero.
    localparam logic [31:0] GOLD = zero_sig();

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  Y;
    logic [7:0]  X;
    logic        dut_reset;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] cap_cnt;

    cs_bist_driver #(
        .N_PAT(N_PAT), .WIN(WIN), .LAT(LAT), .DUT_RST_CYC(DRC),
        .LFSR_SEED(SEED), .SIG_INIT(SIG_INIT), .GOLDEN_SIG(GOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .Y(Y), .X(X),
        .dut_reset(dut_reset), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .cap_cnt(cap_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference model: position in the run timeline plus accumulated result.
    int          m_c;
    logic [31:0] m_sig;
    int          m_cnt;
    logic        m_pass;
    logic [7:0]  xs [N_PAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model across the posedge.
    task automatic cyc(input logic st, input logic rs, input logic [9:0] y);
        logic [7:0] ex;
        logic       edr, ebusy, edone;
        @(negedge clk);
        if (m_c < 0)           begin ex = SEED;          edr = 1'b1; ebusy = 1'b0; edone = 1'b0; end
        else if (m_c < C_STR)  begin ex = SEED;          edr = 1'b1; ebusy = 1'b1; edone = 1'b0; end
        else if (m_c < C_DRN)  begin ex = xs[m_c-C_STR]; edr = 1'b0; ebusy = 1'b1; edone = 1'b0; end
        else if (m_c < C_DONE) begin ex = xs[N_PAT-1];   edr = 1'b0; ebusy = 1'b1; edone = 1'b0; end
        else                   begin ex = xs[N_PAT-1];   edr = 1'b1; ebusy = 1'b0; edone = 1'b1; end
        chk("X", 32'(X), 32'(ex));
        chk("dut_reset", 32'(dut_reset), 32'(edr));
        chk("busy", 32'(busy), 32'(ebusy));
        chk("done", 32'(done), 32'(edone));
        chk("signature", signature, m_sig);
        chk("cap_cnt", 32'(cap_cnt), 32'(m_cnt));
        chk("pass", 32'(pass), 32'(m_pass));
        if (m_c == C_STR + 1) chk("x_s1", 32'(X), 32'h4A);
        if (m_c == C_STR + 2) chk("x_s2", 32'(X), 32'h95);
        start = st;
        reset = rs;
        Y     = y;
        if (!rs) begin
            m_c = -1; m_sig = SIG_INIT; m_cnt = 0; m_pass = 1'b0;
        end else begin
            if (m_c >= CAP_LO && m_c <= CAP_HI) begin
                m_sig = misr(m_sig, y);
                m_cnt++;
            end
            if ((m_c < 0 || m_c >= C_DONE) && st) begin
                m_c = 0; m_sig = SIG_INIT; m_cnt = 0; m_pass = 1'b0;
            end else if (m_c >= 0 && m_c < C_DONE) begin
                m_c++;
                if (m_c == C_DONE) m_pass = (m_sig == GOLD) && (m_cnt == N_CAP);
            end
        end
    endtask

    // Full run: mode 0 drives Y=0 (except Y=1 at cycle flip_c), mode 1 random Y.
    // Extra start pulses are sprinkled while busy.
    task automatic run(input int mode, input int flip_c);
        logic [9:0] y;
        logic       st;
        int         guard;
        cyc(1'b1, 1'b1, 10'd0);
        guard = 0;
        while (m_c >= 0 && m_c < C_DONE && guard < 200) begin
            y  = (mode != 0) ? 10'($urandom) : ((m_c == flip_c) ? 10'd1 : 10'd0);
            st = ($urandom_range(0, 3) == 0);
            cyc(st, 1'b1, y);
            guard++;
        end
        if (guard >= 200) chk("run_timeout", 32'(guard), 32'd0);
        cyc(1'b0, 1'b1, 10'd0);
    endtask

    initial begin
        xs[0] = SEED;
        for (int i = 1; i < N_PAT; i++)
            xs[i] = {xs[i-1][6:0], xs[i-1][7] ^ xs[i-1][5] ^ xs[i-1][4] ^ xs[i-1][3]};
        m_c = -1; m_sig = SIG_INIT; m_cnt = 0; m_pass = 1'b0;
        reset = 1'b0; start = 1'b0; Y = 10'd0;
        repeat (3) @(posedge clk);

        // Reset state, held idle for a few cycles
        repeat (3) cyc(1'b0, 1'b1, 10'd0);

        // Zero-Y run must match the golden signature
        run(0, -1);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_cnt", 32'(cap_cnt), 32'd8);
        chk("zero_sig", signature, GOLD);

        // Random-Y run started from DONE
        run(1, -1);

        // One corrupted capture must fail
        run(0, $urandom_range(CAP_LO, CAP_HI));
        chk("flip_pass", 32'(pass), 32'd0);

        // Mid-stream reset then a clean rerun
        cyc(1'b1, 1'b1, 10'd0);
        repeat ($urandom_range(DRC + 1, C_DRN - 2)) cyc(1'b0, 1'b1, 10'($urandom));
        cyc(1'b0, 1'b0, 10'd0);
        cyc(1'b0, 1'b1, 10'd0);
        run(0, -1);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_sig", signature, GOLD);

        // Start coinciding with reset: reset wins
        cyc(1'b1, 1'b0, 10'd0);
        cyc(1'b0, 1'b1, 10'd0);
        cyc(1'b0, 1'b1, 10'd0);

        // Randomized runs
        for (int r = 0; r < 6; r++)
            run($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? $urandom_range(CAP_LO, CAP_HI) : -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
